// File: rtl/cache_line_fill_pkg.sv
// cache_pkg: shared line-fill types and constants.
// Provides fill_state_t, BLOCK_WORDS, WORD_W, LINE_W and line_t for the cache and refill engine.
package cache_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} fill_state_t;
    localparam int BLOCK_WORDS = 4;
    localparam int WORD_W = 64;
    localparam int LINE_W = BLOCK_WORDS * WORD_W;
    typedef logic [LINE_W-1:0] line_t;
endpackage

// File: rtl/cache_line_fill_if.sv
// cache_line_fill_if: cache request, memory read and line return signals of the refill engine.
// slave modport is the engine side; master modport is the cache/memory side.
interface cache_line_fill_if import cache_pkg::*; #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = WORD_W
) ();
    logic                          req_valid;
    logic                          req_ready;
    logic [ADDR_W-1:0]             req_addr;
    logic                          mem_rd_en;
    logic [ADDR_W-1:0]             mem_addr;
    logic                          mem_rd_valid;
    logic [DATA_W-1:0]             mem_rd_data;
    logic                          line_valid;
    logic                          line_error;
    logic [ADDR_W-1:0]             line_addr;
    logic [DATA_W*BLOCK_WORDS-1:0] line_data;
    logic                          busy;
    modport slave (
        input  req_valid, req_addr, mem_rd_valid, mem_rd_data,
        output req_ready, mem_rd_en, mem_addr, line_valid, line_error, line_addr, line_data, busy
    );
    modport master (
        output req_valid, req_addr, mem_rd_valid, mem_rd_data,
        input  req_ready, mem_rd_en, mem_addr, line_valid, line_error, line_addr, line_data, busy
    );
endinterface

// File: rtl/cache_line_fill_timeout_ctr.sv
// fill_timeout_ctr: counts WAIT cycles without a memory response.
// Ports: clock, reset (async active-low), clr (restart), en (count this cycle),
// expired (this enabled cycle is the TIMEOUT_CYCLES-th in a row).
module fill_timeout_ctr import cache_pkg::*; #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= cnt + W'(1);
    end
    assign expired = en && (cnt == W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/cache_line_fill.sv
// cache_line_fill: four-word line refill engine between cache miss path and main memory.
// Ports: clock, reset (async active-low), bus (cache_line_fill_if.slave: request handshake,
// single-word memory reads, line_valid/line_error/line_addr/line_data return, busy).
// Option: CACHE_FILL_CRITICAL_WORD_FIRST_EN starts reading at req_addr[1:0] and wraps.
module cache_line_fill import cache_pkg::*; #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = WORD_W,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic             clock,
    input logic             reset,
    cache_line_fill_if.slave bus
);
    fill_state_t state;
    logic [1:0]  idx;
    logic [1:0]  cnt;
    logic [1:0]  start;
    logic        expired;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    assign start = bus.req_addr[1:0];
`else
    assign start = 2'd0;
`endif
    // req_ready stays low while reset is asserted even though the state is already IDLE.
    assign bus.req_ready = reset && state == IDLE;
    assign bus.busy = state != IDLE;
    fill_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clock(clock),
        .reset(reset),
        .clr(state == ISSUE),
        .en(state == WAIT && !bus.mem_rd_valid),
        .expired(expired)
    );
    // line_addr doubles as the aligned base for every read of the line.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            idx            <= '0;
            cnt            <= '0;
            bus.mem_rd_en  <= 1'b0;
            bus.mem_addr   <= '0;
            bus.line_valid <= 1'b0;
            bus.line_error <= 1'b0;
            bus.line_addr  <= '0;
            bus.line_data  <= '0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    bus.line_addr <= bus.req_addr & ~ADDR_W'(3);
                    bus.line_data <= '0;
                    bus.mem_addr  <= {bus.req_addr[ADDR_W-1:2], start};
                    bus.mem_rd_en <= 1'b1;
                    idx           <= start;
                    cnt           <= '0;
                    state         <= ISSUE;
                end
                ISSUE: begin
                    bus.mem_rd_en <= 1'b0;
                    state         <= WAIT;
                end
                WAIT: if (bus.mem_rd_valid) begin
                    bus.line_data[DATA_W*int'(idx) +: DATA_W] <= bus.mem_rd_data;
                    if (cnt == 2'd3) begin
                        bus.line_valid <= 1'b1;
                        bus.line_error <= 1'b0;
                        state          <= DONE;
                    end else begin
                        cnt           <= cnt + 2'd1;
                        idx           <= idx + 2'd1;
                        bus.mem_addr  <= {bus.line_addr[ADDR_W-1:2], idx + 2'd1};
                        bus.mem_rd_en <= 1'b1;
                        state         <= ISSUE;
                    end
                end else if (expired) begin
                    bus.line_valid <= 1'b1;
                    bus.line_error <= 1'b1;
                    state          <= DONE;
                end
                DONE: begin
                    bus.line_valid <= 1'b0;
                    bus.line_error <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
